// File: rtl/alu_arbiter.sv
// Round-robin two-port arbiter that sequences one shared 8-bit ALU:
// grant, hold operands for a per-opcode cycle count, capture, then ACK the winner.
module alu_arbiter #(
    parameter int unsigned BASIC_CYCLES = 1,
    parameter int unsigned MUL_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic [2:0] op0_i,
    input  logic [2:0] op1_i,
    input  logic [7:0] a0_i,
    input  logic [7:0] a1_i,
    input  logic [7:0] b0_i,
    input  logic [7:0] b1_i,
    output logic       ack0_o,
    output logic       ack1_o,
    output logic [7:0] result_o,
    output logic       zero_o,
    output logic       error_o,
    output logic       busy_o,
    output logic [7:0] alu_data1_o,
    output logic [7:0] alu_data2_o,
    output logic [2:0] alu_select_o,
    input  logic [7:0] alu_result_i,
    input  logic       alu_zero_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       win_q, win_d;
    logic       illegal_q, illegal_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       busy_q, busy_d;
    logic [7:0] result_q, result_d;
    logic       zero_q, zero_d;
    logic       error_q, error_d;
    logic [7:0] data1_q, data1_d;
    logic [7:0] data2_q, data2_d;
    logic [2:0] sel_q, sel_d;

    logic       win_s;
    logic [2:0] gop_s;
    logic [7:0] ga_s;
    logic [7:0] gb_s;
    logic       glegal_s;

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= 3'b100);
    endfunction

    // Illegal opcodes still take one cycle so the requester always gets an ACK.
    function automatic logic [3:0] op_cycles(input logic [2:0] op);
        logic [3:0] cyc;
        case (op)
            3'b000, 3'b001, 3'b010, 3'b011: cyc = 4'(BASIC_CYCLES);
            3'b100:                         cyc = 4'(MUL_CYCLES);
            default:                        cyc = 4'd1;
        endcase
        return cyc;
    endfunction

    assign win_s    = (req0_i && req1_i) ? ptr_q : req1_i;
    assign gop_s    = win_s ? op1_i : op0_i;
    assign ga_s     = win_s ? a1_i  : a0_i;
    assign gb_s     = win_s ? b1_i  : b0_i;
    assign glegal_s = op_legal(gop_s);

    // Next-state and registered-output logic for the grant/exec/done sequence.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        busy_d    = busy_q;
        result_d  = result_q;
        zero_d    = zero_q;
        error_d   = error_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        sel_d     = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (req0_i || req1_i) begin
                    win_d     = win_s;
                    ptr_d     = ~ptr_q;
                    illegal_d = ~glegal_s;
                    cnt_d     = op_cycles(gop_s);
                    data1_d   = ga_s;
                    data2_d   = gb_s;
                    sel_d     = glegal_s ? gop_s : 3'b000;
                    busy_d    = 1'b1;
                    state_d   = ST_EXEC;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    result_d = illegal_q ? 8'h00 : alu_result_i;
                    zero_d   = illegal_q ? 1'b0  : alu_zero_i;
                    error_d  = illegal_q;
                    ack0_d   = ~win_q;
                    ack1_d   = win_q;
                    cnt_d    = 4'd0;
                    state_d  = ST_DONE;
                end else begin
                    state_d  = ST_EXEC;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 1'b0;
            win_q     <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= 4'd0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            busy_q    <= 1'b0;
            result_q  <= 8'h00;
            zero_q    <= 1'b0;
            error_q   <= 1'b0;
            data1_q   <= 8'h00;
            data2_q   <= 8'h00;
            sel_q     <= 3'b000;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            busy_q    <= busy_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            error_q   <= error_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            sel_q     <= sel_d;
        end
    end

    assign ack0_o       = ack0_q;
    assign ack1_o       = ack1_q;
    assign busy_o       = busy_q;
    assign result_o     = result_q;
    assign zero_o       = zero_q;
    assign error_o      = error_q;
    assign alu_data1_o  = data1_q;
    assign alu_data2_o  = data2_q;
    assign alu_select_o = sel_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer for the shared 8-bit ALU (FORWARD/ADD/AND/OR/MULTIPLY). Two requesters share one ALU instance: the CPU datapath on port 0 and an auxiliary unit on port 1. The block arbitrates round-robin, latches the winner's operands onto the ALU inputs and waits a per-opcode cycle count. It then captures the ALU result and returns it with a one-cycle ACK to the winning port.

## Interface
- BASIC_CYCLES, 1: cycles allowed for FORWARD/ADD/AND/OR (opcodes 000–011); legal range 1–15.
- MUL_CYCLES, 2: cycles allowed for MULTIPLY (opcode 100); legal range 1–15.
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- REQ0 / REQ1  in  1  request from port 0 / port 1; held high until ACK is seen.
- OP0 / OP1  in  3  ALU opcode for each port; 000 FWD, 001 ADD, 010 AND, 011 OR, 100 MUL, 101–111 illegal.
- A0 / A1  in  8  DATA1 operand for each port.
- B0 / B1  in  8  DATA2 operand for each port.
- ACK0 / ACK1  out  1  one-cycle completion pulse to each port.
- RESULT  out  8  registered result of the last completed operation.
- ZERO_OUT  out  1  registered copy of ALU_ZERO, sampled with RESULT.
- ERROR  out  1  registered; set when the last completed operation had an illegal opcode.
- BUSY  out  1  high in every state except IDLE.
- ALU_DATA1 / ALU_DATA2  out  8  registered drive to the ALU's DATA1/DATA2.
- ALU_SELECT  out  3  registered drive to the ALU's SELECT.
- ALU_RESULT  in  8  ALU RESULT.
- ALU_ZERO  in  1  ALU ZERO.

## Operation
- States: IDLE, EXEC, DONE.
- **IDLE:** if any REQ is high, grant one port.
  - Only one REQ high: that port wins.
  - Both high: the port named by the priority pointer PTR wins.
  - PTR toggles to the other port after every grant.
- **Grant edge:**
  - Latch the winner's A, B and OP into ALU_DATA1, ALU_DATA2 and ALU_SELECT.
  - Latch the winner index.
  - Load CNT with MUL_CYCLES for opcode 100, BASIC_CYCLES for opcodes 000–011, or 1 for an illegal opcode.
  - Go to EXEC.
- **Illegal opcode:** ALU_SELECT is driven 000. At capture, RESULT=0x00, ZERO_OUT=0 and ERROR=1.
- **EXEC:** CNT decrements every edge. On the edge where CNT==1:
  - RESULT←ALU_RESULT, ZERO_OUT←ALU_ZERO, ERROR←0 (legal opcodes; illegal capture is defined above).
  - Set ACK for the winning port.
  - Go to DONE.
- **DONE:** the winner's ACK is high for exactly this cycle. Next edge: clear ACK, go to IDLE.
- **Requester rule:** deassert REQ on the edge where ACK is sampled high. The arbiter never samples REQ in DONE.
- **Operand stability:** operands and OP may change freely after the grant edge; the latched copies are used.
- **Arithmetic:** results are 8-bit and wrap modulo 256, as the ALU produces them. The block does not recompute ZERO.
- **Hold:** RESULT, ZERO_OUT and ERROR hold their value until the next capture.
- **Reset (RESET low), at any time including mid-EXEC:**
  - State→IDLE, PTR→0, CNT→0.
  - ACK0, ACK1 and BUSY→0.
  - RESULT, ALU_DATA1 and ALU_DATA2→0x00; ALU_SELECT→000.
  - ZERO_OUT and ERROR→0.
  - The in-flight operation is discarded and no ACK is issued.

## Timing
- Latency: REQ sampled at grant edge k → RESULT valid and ACK high from edge k+L to edge k+L+1. L is the CNT load value.
- Turnaround: the next grant happens no earlier than edge k+L+2.
- Per-port throughput: one operation every L+2 cycles.
- BUSY: high from edge k to edge k+L+1.
- ALU settling: the ALU inputs are stable for L full cycles before capture. The clock period must exceed the ALU's worst-case combinational delay per allotted cycle (MULTIPLY's path is the longest).
- Never high in the same cycle: ACK0 and ACK1 together, or ACK and a grant edge.

## Test plan
- **Single ADD:** port 0 requests ADD with A0=0x05, B0=0x03 → ACK0 one cycle at edge k+1; RESULT=0x08, ZERO_OUT=0; ACK1 never rises.
- **Multiply latency:** port 1 requests MUL with A1=0x07, B1=0x06 (MUL_CYCLES=2) → ACK1 at edge k+2, RESULT=0x2A; BUSY high for 3 cycles.
- **Round-robin fairness:** after reset, both REQ0 and REQ1 held high continuously with fresh ops each time (port 0 AND 0xF0&0x3C, port 1 OR 0x0F|0x30) → grants go 0,1,0,1; RESULTs 0x30, 0x3F, 0x30, 0x3F; no two ACKs overlap.
- **Wrap-around:** port 0 requests ADD with 0xFF+0x01 → RESULT=0x00, ZERO_OUT=1.
- **Illegal opcode:** port 1 requests OP1=3'b110 → ALU_SELECT=000, ACK1 at k+1, RESULT=0x00, ERROR=1. A following legal op clears ERROR to 0.
- **Reset mid-operation:** RESET pulled low during EXEC of a MUL → all outputs at their reset values immediately with no ACK. After release, a simultaneous request from both ports grants port 0 first (PTR=0).
